shft_serializer: RTL and testbench
==================================

Name: shft_serializer

Overview:
Parallel-in/serial-out transmitter that produces the serial bit stream consumed by the team's universal shift register serial inputs.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out one bit per clock, MSB-first (left-shift order) or LSB-first (right-shift order), selected per word.
- Emits frame markers with the stream.
- Sits between a parallel data source and any serial sink in the datapath.

Parameters:
WIDTH, 4, word width in bits; legal range WIDTH >= 2.
GAP, 0, idle cycles inserted after each word before the next word may be accepted; legal range GAP >= 0.

Ports:
Clk  input  1  clock; all logic on the rising edge.
Rst  input  1  synchronous reset, active-low (Rst=0 resets on the next rising Clk edge).
InValid  input  1  source has a word on Datain.
InReady  output  1  block will accept a word this cycle.
Datain  input  WIDTH  parallel word; sampled only on accept.
Dir  input  1  0 = MSB-first (left shift), 1 = LSB-first (right shift); sampled only on accept.
SerOut  output  1  serial data bit.
SerValid  output  1  SerOut carries a word bit this cycle.
SerFirst  output  1  high with the first bit of a word.
SerLast  output  1  high with the last bit of a word.
Busy  output  1  state is not IDLE.

Behaviour:
- Reset:
  - Rst=0 at an edge forces state IDLE and clears the shift register and bit counter.
  - SerOut, SerValid, SerFirst, SerLast and Busy are all 0 after reset.
  - InReady is 0 while Rst=0.
  - Reset mid-word aborts the word: no further bits are sent, and SerLast is not emitted for it.
- States: IDLE, SHIFT, GAP.
- Accept: a word is taken at an edge where InValid=1 and InReady=1. Datain and Dir are latched into the shift register and a direction flag at that edge.
- InReady (combinational from state/counter, gated by Rst) is 1 when either holds:
  - state is IDLE, or
  - state is SHIFT, the counter equals WIDTH-1, and GAP=0 (back-to-back accept).
- Latency: the first bit appears on SerOut in the cycle after the accepting edge. Bit i is presented in cycle i+1 after accept, for i = 0..WIDTH-1.
- Bit order:
  - Dir=0 sends Datain[WIDTH-1] first, down to Datain[0].
  - Dir=1 sends Datain[0] first, up to Datain[WIDTH-1].
- Output timing: all serial outputs are registered.
  - SerValid=1 for exactly WIDTH consecutive cycles per word.
  - SerFirst=1 with bit 0 only; SerLast=1 with bit WIDTH-1 only.
  - SerOut=0 whenever SerValid=0.
- Counter: width max(1, clog2(WIDTH)). It counts 0..WIDTH-1 in SHIFT and never wraps mid-word.
- Transitions:
  - IDLE -> SHIFT on accept.
  - SHIFT stays in SHIFT while counter < WIDTH-1.
  - At counter = WIDTH-1, the next state is:
    - GAP if GAP > 0;
    - otherwise SHIFT with the new word if one is accepted that edge;
    - otherwise IDLE.
  - GAP -> IDLE after exactly GAP cycles, with InReady=0 throughout GAP.
- Back-to-back (GAP=0): SerValid stays 1 continuously across words. SerLast of word n and SerFirst of word n+1 occur on adjacent cycles.
- Mid-word input changes: changes on Datain, Dir or InValid while in SHIFT or GAP have no effect on the word in flight.
- Busy=1 in SHIFT and GAP.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_SHIFT, ST_GAP) and direction constants (DIR_MSB_FIRST=0, DIR_LSB_FIRST=1).
- Sub-module: one natural sub-module, shft_serializer_piso, holding the WIDTH-bit load/shift-left/shift-right register.
- The FSM, counter and handshake logic live in the top module.

Test Plan:
1. Reset values: hold Rst=0 for 2 edges with InValid=1 -> all outputs 0, InReady=0. Release Rst -> InReady=1, Busy=0.
2. MSB-first: WIDTH=4, accept Datain=4'b0101, Dir=0 -> SerOut=0,1,0,1 on 4 consecutive cycles starting one cycle after accept; SerFirst on cycle 1, SerLast on cycle 4; then IDLE with InReady=1.
3. LSB-first: accept 4'b0011, Dir=1 -> SerOut=1,1,0,0. Toggling Dir and setting Datain=4'b1111 mid-word leaves the stream unchanged.
4. Back-to-back with GAP=0: InValid held 1 with words 4'b1001 then 4'b0110, Dir=0 -> 8 contiguous SerValid cycles, SerOut=1,0,0,1,0,1,1,0; second accept occurs on the SerLast cycle.
5. GAP=2: two words offered continuously -> after SerLast, InReady=0 and Busy=1 for exactly 2 cycles; the second word's first bit arrives 4 cycles after the first word's SerLast (accept on the 3rd cycle after SerLast, first bit on the 4th).
6. Reset mid-word: accept 4'b1010, Dir=0; drive Rst=0 after 2 bits -> SerValid=0 from the edge where Rst=0 is sampled, no SerLast, and state IDLE after Rst=1.

Source files
------------

// File: rtl/shft_serializer_pkg.sv
// Shared encodings for the parallel-in/serial-out serializer.
// The FSM state values and the shift-direction flag values live here.
package shft_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    // Width of a counter that has to hold the values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shft_serializer_piso.sv
// WIDTH-bit load / shift-left / shift-right register.
// next_bit_o is the bit that will sit at the output end once the next shift has happened.
module shft_serializer_piso
    import shft_serializer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             next_bit_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            if (dir_i == DIR_LSB_FIRST) begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end else begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // The current bit is already on the registered serial output, so the lookahead bit is fed out.
    assign next_bit_o = (dir_i == DIR_LSB_FIRST) ? shreg_q[1] : shreg_q[WIDTH-2];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/shft_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word over valid/ready and shifts it out
// MSB-first or LSB-first, with first/last frame markers and optional idle gap between words.
module shft_serializer
    import shft_serializer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] Datain,
    input  logic             Dir,
    output logic             SerOut,
    output logic             SerValid,
    output logic             SerFirst,
    output logic             SerLast,
    output logic             Busy
);

    // Handshake: a word moves on a rising Clk edge where InValid and InReady are both 1;
    // the source holds Datain/Dir while InValid=1, and InReady never depends on InValid.

    localparam int CW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          dir_q, dir_d;
    logic          out_q, out_d;
    logic          valid_q, valid_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          load;
    logic          shift_en;
    logic          accept;
    logic          cnt_at_last;
    logic          next_bit;

    shft_serializer_piso #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk_i     (Clk),
        .rst_ni    (Rst),
        .load_i    (load),
        .shift_i   (shift_en),
        .dir_i     (dir_q),
        .data_i    (Datain),
        .next_bit_o(next_bit)
    );

    always_comb begin
        cnt_at_last = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
        InReady     = Rst && ((state_q == ST_IDLE) || (cnt_at_last && (GAP == 0)));
        accept      = InValid && InReady;

        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        dir_d    = dir_q;
        out_d    = 1'b0;
        valid_d  = 1'b0;
        first_d  = 1'b0;
        last_d   = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;

        case (state_q)
            ST_SHIFT: begin
                if (!cnt_at_last) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    valid_d  = 1'b1;
                    out_d    = next_bit;
                    last_d   = (cnt_d == CNT_LAST);
                end else if (GAP > 0) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept is only possible from IDLE or the last SHIFT cycle, so it overrides the above.
        if (accept) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            dir_d   = Dir;
            load    = 1'b1;
            valid_d = 1'b1;
            first_d = 1'b1;
            out_d   = (Dir == DIR_LSB_FIRST) ? Datain[0] : Datain[WIDTH-1];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            dir_q   <= DIR_MSB_FIRST;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            dir_q   <= dir_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign SerOut   = out_q;
    assign SerValid = valid_q;
    assign SerFirst = first_q;
    assign SerLast  = last_q;
    assign Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shft_serializer.sv
// Directed bench for shft_serializer: one instance with GAP=0 and one with GAP=2, WIDTH=4.
// Serial outputs are compared as {SerValid, SerOut, SerFirst, SerLast}.
module tb_shft_serializer;

    logic       clk;
    logic       rst;

    logic       inv0, rdy0, dir0, so0, sv0, sf0, sl0, busy0;
    logic [3:0] din0;
    logic       inv2, rdy2, dir2, so2, sv2, sf2, sl2, busy2;
    logic [3:0] din2;

    int n_checks;
    int n_fail;

    shft_serializer #(.WIDTH(4), .GAP(0)) u_gap0 (
        .Clk(clk), .Rst(rst), .InValid(inv0), .InReady(rdy0), .Datain(din0), .Dir(dir0),
        .SerOut(so0), .SerValid(sv0), .SerFirst(sf0), .SerLast(sl0), .Busy(busy0)
    );

    shft_serializer #(.WIDTH(4), .GAP(2)) u_gap2 (
        .Clk(clk), .Rst(rst), .InValid(inv2), .InReady(rdy2), .Datain(din2), .Dir(dir2),
        .SerOut(so2), .SerValid(sv2), .SerFirst(sf2), .SerLast(sl2), .Busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b0;
        inv0 = 1'b1; din0 = 4'b1111; dir0 = 1'b0;
        inv2 = 1'b1; din2 = 4'b1111; dir2 = 1'b0;

        // reset values
        tick();
        tick();
        chk("rst_ser0",   {sv0, so0, sf0, sl0}, 4'b0000);
        chk("rst_ctl0",   {rdy0, busy0}, 2'b00);
        chk("rst_ser2",   {sv2, so2, sf2, sl2}, 4'b0000);
        chk("rst_ctl2",   {rdy2, busy2}, 2'b00);
        inv0 = 1'b0;
        inv2 = 1'b0;
        rst  = 1'b1;
        #1;
        chk("rel_ctl0",   {rdy0, busy0}, 2'b10);
        chk("rel_ctl2",   {rdy2, busy2}, 2'b10);

        // MSB-first 0101
        din0 = 4'b0101; dir0 = 1'b0; inv0 = 1'b1;
        tick();
        inv0 = 1'b0;
        chk("msb_b0",     {sv0, so0, sf0, sl0}, 4'b1010);
        chk("msb_b0_ctl", {rdy0, busy0}, 2'b01);
        tick();
        chk("msb_b1",     {sv0, so0, sf0, sl0}, 4'b1100);
        tick();
        chk("msb_b2",     {sv0, so0, sf0, sl0}, 4'b1000);
        tick();
        chk("msb_b3",     {sv0, so0, sf0, sl0}, 4'b1101);
        chk("msb_b3_rdy", {7'd0, rdy0}, 8'd1);
        tick();
        chk("msb_idle",   {sv0, so0, sf0, sl0}, 4'b0000);
        chk("msb_idle_ctl", {rdy0, busy0}, 2'b10);

        // LSB-first 0011 with Datain/Dir disturbed mid-word
        din0 = 4'b0011; dir0 = 1'b1; inv0 = 1'b1;
        tick();
        inv0 = 1'b0; din0 = 4'b1111; dir0 = 1'b0;
        chk("lsb_b0",     {sv0, so0, sf0, sl0}, 4'b1110);
        tick();
        dir0 = 1'b1;
        chk("lsb_b1",     {sv0, so0, sf0, sl0}, 4'b1100);
        tick();
        dir0 = 1'b0;
        chk("lsb_b2",     {sv0, so0, sf0, sl0}, 4'b1000);
        tick();
        chk("lsb_b3",     {sv0, so0, sf0, sl0}, 4'b1001);
        tick();
        chk("lsb_idle",   {sv0, so0, sf0, sl0}, 4'b0000);

        // back-to-back 1001 then 0110, GAP=0
        din0 = 4'b1001; dir0 = 1'b0; inv0 = 1'b1;
        tick();
        din0 = 4'b0110;
        chk("b2b_w0b0",   {sv0, so0, sf0, sl0}, 4'b1110);
        chk("b2b_w0b0_rdy", {7'd0, rdy0}, 8'd0);
        tick();
        chk("b2b_w0b1",   {sv0, so0, sf0, sl0}, 4'b1000);
        tick();
        chk("b2b_w0b2",   {sv0, so0, sf0, sl0}, 4'b1000);
        tick();
        chk("b2b_w0b3",   {sv0, so0, sf0, sl0}, 4'b1101);
        chk("b2b_w0b3_rdy", {7'd0, rdy0}, 8'd1);
        tick();
        inv0 = 1'b0;
        chk("b2b_w1b0",   {sv0, so0, sf0, sl0}, 4'b1010);
        tick();
        chk("b2b_w1b1",   {sv0, so0, sf0, sl0}, 4'b1100);
        tick();
        chk("b2b_w1b2",   {sv0, so0, sf0, sl0}, 4'b1100);
        tick();
        chk("b2b_w1b3",   {sv0, so0, sf0, sl0}, 4'b1001);
        tick();
        chk("b2b_idle",   {sv0, so0, sf0, sl0, rdy0, busy0}, 6'b000010);

        // GAP=2: 1100 then 0001 offered continuously
        din2 = 4'b1100; dir2 = 1'b0; inv2 = 1'b1;
        tick();
        din2 = 4'b0001;
        chk("gap_w0b0",   {sv2, so2, sf2, sl2}, 4'b1110);
        tick();
        chk("gap_w0b1",   {sv2, so2, sf2, sl2}, 4'b1100);
        tick();
        chk("gap_w0b2",   {sv2, so2, sf2, sl2}, 4'b1000);
        tick();
        chk("gap_w0b3",   {sv2, so2, sf2, sl2}, 4'b1001);
        chk("gap_w0b3_rdy", {7'd0, rdy2}, 8'd0);
        tick();
        chk("gap_c1",     {sv2, so2, sf2, sl2, rdy2, busy2}, 6'b000001);
        tick();
        chk("gap_c2",     {sv2, so2, sf2, sl2, rdy2, busy2}, 6'b000001);
        tick();
        chk("gap_c3_acc", {sv2, so2, sf2, sl2, rdy2, busy2}, 6'b000010);
        tick();
        inv2 = 1'b0;
        chk("gap_w1b0",   {sv2, so2, sf2, sl2}, 4'b1010);
        tick();
        chk("gap_w1b1",   {sv2, so2, sf2, sl2}, 4'b1000);
        tick();
        chk("gap_w1b2",   {sv2, so2, sf2, sl2}, 4'b1000);
        tick();
        chk("gap_w1b3",   {sv2, so2, sf2, sl2}, 4'b1101);
        tick();
        chk("gap2_c1",    {sv2, rdy2, busy2}, 3'b001);
        tick();
        chk("gap2_c2",    {sv2, rdy2, busy2}, 3'b001);
        tick();
        chk("gap2_idle",  {sv2, rdy2, busy2}, 3'b010);

        // reset mid-word: 1010 MSB-first, Rst=0 after two bits
        din0 = 4'b1010; dir0 = 1'b0; inv0 = 1'b1;
        tick();
        inv0 = 1'b0;
        chk("mrst_b0",    {sv0, so0, sf0, sl0}, 4'b1110);
        tick();
        chk("mrst_b1",    {sv0, so0, sf0, sl0}, 4'b1000);
        rst = 1'b0;
        #1;
        chk("mrst_rdy_low", {7'd0, rdy0}, 8'd0);
        tick();
        chk("mrst_abort", {sv0, so0, sf0, sl0, rdy0, busy0}, 6'b000000);
        rst = 1'b1;
        tick();
        chk("mrst_after1", {sv0, so0, sf0, sl0, rdy0, busy0}, 6'b000010);
        tick();
        chk("mrst_after2", {sv0, so0, sf0, sl0, rdy0, busy0}, 6'b000010);
        tick();
        chk("mrst_after3", {sv0, so0, sf0, sl0, rdy0, busy0}, 6'b000010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
